// File: rtl/uc_rr_scheduler_pkg.sv
// Shared types and sizing for the unit-clause scheduler slice.
package uc_pkg;

  localparam int unsigned NUM_ENGINE = 4;
  localparam int unsigned UC_LENGTH  = 1024;
  localparam int unsigned UCQ_SIZE   = 16;
  localparam int unsigned LIT_W      = $clog2(UC_LENGTH);
  localparam int unsigned PTR_W      = $clog2(UCQ_SIZE);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam int unsigned ENG_W      = $clog2(NUM_ENGINE);

  // Signed literal: positive = var true, negative = var false, 0 = null
  typedef logic signed [LIT_W-1:0] lit_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CONFLICT,
    DONE
  } uc_state_t;

  // Opposite polarity of a literal
  function automatic lit_t lit_neg(input lit_t l);
    return lit_t'(-l);
  endfunction

endpackage

// File: rtl/uc_rr_scheduler_if.sv
// Handshake bundle between the scheduler, clause memory and the BCP engines.
interface uc_rr_scheduler_if;
  import uc_pkg::*;

  logic                  start;
  logic                  mem2uca_valid;
  lit_t                  mem2uca;
  logic                  mem2uca_done;
  logic                  mem2uca_ready;
  lit_t                  eng2uca_min [NUM_ENGINE];
  logic [NUM_ENGINE-1:0] eng2uca_valid;
  logic [NUM_ENGINE-1:0] eng2uca_empty;
  logic [NUM_ENGINE-1:0] uca2eng_full;
  logic [NUM_ENGINE-1:0] uca2eng_pop;
  lit_t                  uca2eng;
  logic                  uca2eng_valid;
  logic                  conflict;
  logic                  done;
  logic [CNT_W-1:0]      ucq_count;

  // Scheduler side
  modport master (
    input  start, mem2uca_valid, mem2uca, mem2uca_done,
    input  eng2uca_min, eng2uca_valid, eng2uca_empty, uca2eng_full,
    output mem2uca_ready, uca2eng_pop, uca2eng, uca2eng_valid,
    output conflict, done, ucq_count
  );

  // Memory / engine side
  modport slave (
    output start, mem2uca_valid, mem2uca, mem2uca_done,
    output eng2uca_min, eng2uca_valid, eng2uca_empty, uca2eng_full,
    input  mem2uca_ready, uca2eng_pop, uca2eng, uca2eng_valid,
    input  conflict, done, ucq_count
  );

endinterface

// File: rtl/uc_rr_scheduler_fifo_cam.sv
// Circular UC FIFO with a parallel equal / negated match on one search literal.
module uc_fifo_cam
  import uc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  lit_t             i_push_lit,
  input  logic             i_pop,
  input  lit_t             i_search,
  output lit_t             o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_eq_hit,
  output logic             o_neg_hit
);

  lit_t                r_mem [UCQ_SIZE];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic                w_do_push;
  logic                w_do_pop;
  logic [UCQ_SIZE-1:0] w_valid;
  logic [UCQ_SIZE-1:0] w_eq;
  logic [UCQ_SIZE-1:0] w_neg;

  assign o_full    = (r_count == CNT_W'(UCQ_SIZE));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_head];
  assign o_count   = r_count;
  assign o_eq_hit  = |w_eq;
  assign o_neg_hit = |w_neg;

  // Occupied-slot mask from head/count, then compare every live entry
  always_comb begin
    w_valid = '0;
    w_eq    = '0;
    w_neg   = '0;
    for (int k = 0; k < int'(UCQ_SIZE); k++) begin
      w_valid[k] = ({1'b0, PTR_W'(PTR_W'(k) - r_head)} < r_count);
      w_eq[k]    = w_valid[k] && (r_mem[k] == i_search);
      w_neg[k]   = w_valid[k] && (r_mem[k] == lit_neg(i_search));
    end
  end

  // Pointer and occupancy update; push+pop leaves the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + PTR_W'(1);
      if (w_do_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_tail] <= i_push_lit;
  end

endmodule

// File: rtl/uc_rr_scheduler.sv
// Unit-clause scheduler: memory load, round-robin engine pops, broadcast,
// conflict and quiescence detection.
module uc_rr_scheduler
  import uc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  uc_rr_scheduler_if.master  bus
);

  uc_state_t             r_state;
  uc_state_t             w_state_nxt;
  logic [ENG_W-1:0]      r_rr_ptr;
  logic                  r_quiet_seen;
  lit_t                  r_uca2eng;
  logic                  r_uca2eng_valid;
  logic                  r_conflict;
  logic                  r_done;

  logic [NUM_ENGINE-1:0] w_req;
  logic [NUM_ENGINE-1:0] w_gnt;
  logic [ENG_W-1:0]      w_gnt_idx;
  logic                  w_gnt_any;
  logic                  w_room;
  logic                  w_mem_ready;
  lit_t                  w_search;
  logic                  w_consume;
  logic                  w_push;
  logic                  w_conflict_det;
  logic                  w_bcast_raw;
  logic                  w_bcast;
  logic                  w_quiet;

  lit_t                  w_head;
  logic [CNT_W-1:0]      w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_eq_hit;
  logic                  w_neg_hit;

  uc_fifo_cam u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_lit (w_search),
    .i_pop      (w_bcast),
    .i_search   (w_search),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_eq_hit   (w_eq_hit),
    .o_neg_hit  (w_neg_hit)
  );

  assign w_req       = bus.eng2uca_valid & ~bus.eng2uca_empty;
  assign w_mem_ready = (r_state == LOAD) && !w_full;
  // Broadcast candidate ignores conflict so grant room has no loop through it
  assign w_bcast_raw = (r_state == RUN) && !w_empty && (bus.uca2eng_full == '0);
  assign w_bcast     = w_bcast_raw && !w_conflict_det;
  assign w_room      = (r_state == RUN) && (!w_full || w_bcast_raw);
  assign w_quiet     = (r_state == RUN) && w_empty && (&bus.eng2uca_empty) &&
                       !w_gnt_any && !w_bcast_raw;

  // Round-robin scan starting at the pointer, wrapping over all engines
  always_comb begin
    logic [ENG_W-1:0] idx;
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    idx       = '0;
    for (int off = 0; off < int'(NUM_ENGINE); off++) begin
      idx = r_rr_ptr + ENG_W'(off);
      if (!w_gnt_any && w_room && w_req[idx]) begin
        w_gnt[idx] = 1'b1;
        w_gnt_idx  = idx;
        w_gnt_any  = 1'b1;
      end
    end
  end

  // Select the literal offered this cycle and classify it against the FIFO
  always_comb begin
    w_search  = '0;
    w_consume = 1'b0;
    if (r_state == LOAD) begin
      w_search  = bus.mem2uca;
      w_consume = bus.mem2uca_valid && w_mem_ready;
    end else begin
      w_search  = bus.eng2uca_min[w_gnt_idx];
      w_consume = w_gnt_any;
    end
    w_conflict_det = w_consume && (w_search != '0) && w_neg_hit;
    w_push         = w_consume && (w_search != '0) && !w_eq_hit && !w_neg_hit;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.start) w_state_nxt = LOAD;
      LOAD: begin
        if (w_conflict_det)        w_state_nxt = CONFLICT;
        else if (bus.mem2uca_done) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_conflict_det)               w_state_nxt = CONFLICT;
        else if (w_quiet && r_quiet_seen) w_state_nxt = DONE;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Pointer, broadcast register, quiescence history and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr        <= '0;
      r_quiet_seen    <= 1'b0;
      r_uca2eng       <= '0;
      r_uca2eng_valid <= 1'b0;
      r_conflict      <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      if (w_gnt_any) r_rr_ptr <= w_gnt_idx + ENG_W'(1);
      r_quiet_seen    <= w_quiet;
      r_uca2eng_valid <= w_bcast;
      if (w_bcast) r_uca2eng <= w_head;
      r_conflict      <= (w_state_nxt == CONFLICT);
      r_done          <= (w_state_nxt == DONE);
    end
  end

  assign bus.mem2uca_ready = w_mem_ready;
  assign bus.uca2eng_pop   = w_gnt;
  assign bus.uca2eng       = r_uca2eng;
  assign bus.uca2eng_valid = r_uca2eng_valid;
  assign bus.conflict      = r_conflict;
  assign bus.done          = r_done;
  assign bus.ucq_count     = w_count;

endmodule

// File: tb/tb_uc_rr_scheduler.sv
// Directed bench for uc_rr_scheduler.
module tb_uc_rr_scheduler;
  import uc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  uc_rr_scheduler_if bus ();

  uc_rr_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    bus.start         = 1'b0;
    bus.mem2uca_valid = 1'b0;
    bus.mem2uca       = '0;
    bus.mem2uca_done  = 1'b0;
    for (int i = 0; i < int'(NUM_ENGINE); i++) bus.eng2uca_min[i] = '0;
    bus.eng2uca_valid = '0;
    bus.eng2uca_empty = '1;
    bus.uca2eng_full  = '0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start_load();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic push_mem(input int v);
    bus.mem2uca_valid = 1'b1;
    bus.mem2uca       = lit_t'(v);
    @(posedge clk); #1;
    bus.mem2uca_valid = 1'b0;
    bus.mem2uca       = '0;
  endtask

  task automatic finish_load();
    bus.mem2uca_done = 1'b1;
    @(posedge clk); #1;
    bus.mem2uca_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.mem2uca_valid = 1'b1;
    #1;
    total++; if (bus.ucq_count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.ucq_count); end
    total++; if (bus.mem2uca_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus.mem2uca_ready); end
    total++; if (bus.uca2eng_pop !== 4'b0000) begin bad++; $display("FAIL rst_pop got=%b exp=0000", bus.uca2eng_pop); end
    total++; if (bus.uca2eng_valid !== 1'b0 || bus.uca2eng !== 10'sd0) begin bad++; $display("FAIL rst_bcast got=%b/%0d exp=0/0", bus.uca2eng_valid, bus.uca2eng); end
    total++; if (bus.conflict !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", bus.conflict, bus.done); end
    bus.mem2uca_valid = 1'b0;
  endtask

  task automatic test_load();
    int exp_l [5] = '{10, 20, 30, 40, 50};
    int k      = 0;
    int last   = -1;
    int done_c = -1;
    do_reset();
    start_load();
    for (int i = 0; i < 5; i++) push_mem(exp_l[i]);
    finish_load();
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus.uca2eng_valid === 1'b1) begin
        if (k < 5) begin
          total++;
          if (int'(bus.uca2eng) !== exp_l[k]) begin bad++; $display("FAIL load_strobe%0d got=%0d exp=%0d", k, bus.uca2eng, exp_l[k]); end
        end
        k++;
        last = c;
      end
      if (bus.done === 1'b1 && done_c < 0) done_c = c;
    end
    total++; if (k !== 5) begin bad++; $display("FAIL load_nstrobe got=%0d exp=5", k); end
    total++; if (done_c - last !== 2) begin bad++; $display("FAIL load_done_lat got=%0d exp=2", done_c - last); end
    total++; if (bus.ucq_count !== 5'd0 || bus.conflict !== 1'b0) begin bad++; $display("FAIL load_end got=%0d/%b exp=0/0", bus.ucq_count, bus.conflict); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_pop [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000};
    do_reset();
    start_load();
    bus.eng2uca_min[0] = -10'sd1;
    bus.eng2uca_min[1] =  10'sd3;
    bus.eng2uca_min[2] = -10'sd3;
    bus.eng2uca_min[3] =  10'sd5;
    bus.eng2uca_valid  = 4'b1111;
    bus.eng2uca_empty  = 4'b0000;
    bus.uca2eng_full   = 4'b1111;
    finish_load();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      total++; if (bus.uca2eng_pop !== exp_pop[c]) begin bad++; $display("FAIL rr_pop%0d got=%b exp=%b", c, bus.uca2eng_pop, exp_pop[c]); end
    end
    total++; if (bus.conflict !== 1'b1) begin bad++; $display("FAIL rr_conflict got=%b exp=1", bus.conflict); end
    total++; if (bus.ucq_count !== 5'd2) begin bad++; $display("FAIL rr_count got=%0d exp=2", bus.ucq_count); end
    repeat (3) @(posedge clk); #1;
    total++; if (bus.conflict !== 1'b1 || bus.uca2eng_pop !== 4'b0000 || bus.done !== 1'b0) begin bad++; $display("FAIL rr_sticky got=%b/%b/%b exp=1/0000/0", bus.conflict, bus.uca2eng_pop, bus.done); end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    start_load();
    for (int i = 0; i < 4; i++) bus.eng2uca_min[i] = lit_t'(i + 1);
    bus.eng2uca_valid = 4'b1111;
    bus.eng2uca_empty = 4'b0000;
    bus.uca2eng_full  = 4'b1111;
    finish_load();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      total++; if (bus.uca2eng_pop !== 4'(1 << c)) begin bad++; $display("FAIL wrap_pop%0d got=%b exp=%b", c, bus.uca2eng_pop, 4'(1 << c)); end
    end
    @(posedge clk); #1;
    bus.eng2uca_min[0] = 10'sd6;
    bus.eng2uca_min[3] = 10'sd7;
    bus.eng2uca_valid  = 4'b1001;
    bus.eng2uca_empty  = 4'b0110;
    #1;
    total++; if (bus.ucq_count !== 5'd4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", bus.ucq_count); end
    total++; if (bus.uca2eng_pop !== 4'b0001) begin bad++; $display("FAIL wrap_ptr got=%b exp=0001", bus.uca2eng_pop); end
  endtask

  task automatic test_conflict();
    do_reset();
    start_load();
    push_mem(7);
    bus.uca2eng_full   = 4'b1111;
    bus.eng2uca_min[2] = -10'sd7;
    bus.eng2uca_valid  = 4'b0100;
    bus.eng2uca_empty  = 4'b1011;
    finish_load();
    total++; if (bus.uca2eng_pop !== 4'b0100) begin bad++; $display("FAIL cf_pop got=%b exp=0100", bus.uca2eng_pop); end
    @(posedge clk); #1;
    total++; if (bus.conflict !== 1'b1 || bus.uca2eng_pop !== 4'b0000) begin bad++; $display("FAIL cf_flag got=%b/%b exp=1/0000", bus.conflict, bus.uca2eng_pop); end
    bus.uca2eng_full = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++; if (bus.uca2eng_valid !== 1'b0 || bus.conflict !== 1'b1) begin bad++; $display("FAIL cf_hold%0d got=%b/%b exp=0/1", c, bus.uca2eng_valid, bus.conflict); end
    end
    total++; if (bus.ucq_count !== 5'd1) begin bad++; $display("FAIL cf_count got=%0d exp=1", bus.ucq_count); end
    do_reset();
    #1;
    total++; if (bus.conflict !== 1'b0) begin bad++; $display("FAIL cf_clear got=%b exp=0", bus.conflict); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    start_load();
    bus.uca2eng_full = 4'b0100;
    push_mem(8);
    push_mem(9);
    finish_load();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (bus.uca2eng_valid !== 1'b0) begin bad++; $display("FAIL bp_stall%0d got=%b exp=0", c, bus.uca2eng_valid); end
    end
    total++; if (bus.ucq_count !== 5'd2) begin bad++; $display("FAIL bp_count got=%0d exp=2", bus.ucq_count); end
    bus.uca2eng_full = 4'b0000;
    @(posedge clk); #1;
    total++; if (bus.uca2eng_valid !== 1'b1 || bus.uca2eng !== 10'sd8) begin bad++; $display("FAIL bp_first got=%b/%0d exp=1/8", bus.uca2eng_valid, bus.uca2eng); end
    @(posedge clk); #1;
    total++; if (bus.uca2eng_valid !== 1'b1 || bus.uca2eng !== 10'sd9) begin bad++; $display("FAIL bp_second got=%b/%0d exp=1/9", bus.uca2eng_valid, bus.uca2eng); end
  endtask

  task automatic test_full_dup();
    do_reset();
    start_load();
    for (int i = 0; i < 16; i++) push_mem(10 + i);
    bus.mem2uca_valid = 1'b1;
    bus.mem2uca       = 10'sd26;
    #1;
    total++; if (bus.mem2uca_ready !== 1'b0 || bus.ucq_count !== 5'd16) begin bad++; $display("FAIL fd_full got=%b/%0d exp=0/16", bus.mem2uca_ready, bus.ucq_count); end
    @(posedge clk); #1;
    bus.mem2uca_valid = 1'b0;
    total++; if (bus.ucq_count !== 5'd16) begin bad++; $display("FAIL fd_nopush got=%0d exp=16", bus.ucq_count); end
    bus.uca2eng_full   = 4'b1111;
    bus.eng2uca_min[1] = 10'sd12;
    bus.eng2uca_valid  = 4'b0010;
    bus.eng2uca_empty  = 4'b1101;
    finish_load();
    total++; if (bus.uca2eng_pop !== 4'b0000) begin bad++; $display("FAIL fd_blocked got=%b exp=0000", bus.uca2eng_pop); end
    @(posedge clk); #1;
    bus.uca2eng_full = 4'b0000;
    #1;
    total++; if (bus.uca2eng_pop !== 4'b0010) begin bad++; $display("FAIL fd_popbcast got=%b exp=0010", bus.uca2eng_pop); end
    @(posedge clk); #1;
    total++; if (bus.uca2eng_valid !== 1'b1 || bus.uca2eng !== 10'sd10 || bus.ucq_count !== 5'd15) begin bad++; $display("FAIL fd_dup got=%b/%0d/%0d exp=1/10/15", bus.uca2eng_valid, bus.uca2eng, bus.ucq_count); end
    bus.uca2eng_full   = 4'b1111;
    bus.eng2uca_min[1] = 10'sd0;
    #1;
    total++; if (bus.uca2eng_pop !== 4'b0010) begin bad++; $display("FAIL fd_zero_pop got=%b exp=0010", bus.uca2eng_pop); end
    @(posedge clk); #1;
    total++; if (bus.ucq_count !== 5'd15 || bus.uca2eng_valid !== 1'b0) begin bad++; $display("FAIL fd_zero got=%0d/%b exp=15/0", bus.ucq_count, bus.uca2eng_valid); end
    bus.eng2uca_min[1] = 10'sd13;
    @(posedge clk); #1;
    total++; if (bus.ucq_count !== 5'd15) begin bad++; $display("FAIL fd_dup2 got=%0d exp=15", bus.ucq_count); end
    bus.eng2uca_min[1] = 10'sd26;
    @(posedge clk); #1;
    total++; if (bus.ucq_count !== 5'd16) begin bad++; $display("FAIL fd_newpush got=%0d exp=16", bus.ucq_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_load();
    bus.uca2eng_full = 4'b1111;
    for (int i = 1; i <= 4; i++) push_mem(i);
    finish_load();
    total++; if (bus.ucq_count !== 5'd4) begin bad++; $display("FAIL rm_before got=%0d exp=4", bus.ucq_count); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (bus.ucq_count !== 5'd0 || bus.uca2eng_valid !== 1'b0 || bus.uca2eng !== 10'sd0) begin bad++; $display("FAIL rm_clear got=%0d/%b/%0d exp=0/0/0", bus.ucq_count, bus.uca2eng_valid, bus.uca2eng); end
    bus.mem2uca_valid = 1'b1;
    bus.mem2uca       = 10'sd5;
    #1;
    total++; if (bus.mem2uca_ready !== 1'b0 || bus.conflict !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL rm_idle got=%b/%b/%b exp=0/0/0", bus.mem2uca_ready, bus.conflict, bus.done); end
    bus.mem2uca_valid = 1'b0;
    start_load();
    total++; if (bus.mem2uca_ready !== 1'b1) begin bad++; $display("FAIL rm_restart got=%b exp=1", bus.mem2uca_ready); end
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    test_reset();
    test_load();
    test_round_robin();
    test_rr_wrap();
    test_conflict();
    test_back_pressure();
    test_full_dup();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
